// File: rtl/ram_bridge_width_adapter_if.sv
// Bridge-side and RAM-side signal bundle for ram_bridge_width_adapter.
// The adapter uses the slave view; the surrounding bridge/RAM environment uses master.
interface ram_bridge_width_adapter_if #(
  parameter int unsigned RAM_DW = 8,
  parameter int unsigned ADDR_W = 26
) ();
  logic              bigendin;
  logic [31:0]       bridge_addr;
  logic              bridge_rd;
  logic              bridge_wr;
  logic [31:0]       bridge_wr_data;
  logic [31:0]       bridge_rd_data;
  logic              bridge_processing;
  logic              bridge_completed;
  logic              err_overflow;
  logic              err_collision;
  logic              err_clear;
  logic              word_rd;
  logic              word_wr;
  logic [ADDR_W-1:0] word_addr;
  logic [RAM_DW-1:0] word_data;
  logic [RAM_DW-1:0] word_q;
  logic              word_busy;

  modport slave (
    input  bigendin, bridge_addr, bridge_rd, bridge_wr, bridge_wr_data, err_clear,
           word_q, word_busy,
    output bridge_rd_data, bridge_processing, bridge_completed, err_overflow,
           err_collision, word_rd, word_wr, word_addr, word_data
  );

  modport master (
    output bigendin, bridge_addr, bridge_rd, bridge_wr, bridge_wr_data, err_clear,
           word_q, word_busy,
    input  bridge_rd_data, bridge_processing, bridge_completed, err_overflow,
           err_collision, word_rd, word_wr, word_addr, word_data
  );
endinterface

// File: rtl/ram_bridge_width_adapter.sv
// Splits 32-bit bridge read/write requests into 32/RAM_DW narrow RAM beats, with a
// one-entry pending buffer, one completion pulse per transaction and sticky error flags.
module ram_bridge_width_adapter #(
  parameter int unsigned RAM_DW        = 8,
  parameter int unsigned ADDR_W        = 26,
  parameter logic [7:0]  IGNORE_PREFIX = 8'hF8
) (
  input logic                       clk_sys,
  input logic                       reset,
  ram_bridge_width_adapter_if.slave bus
);
  localparam int unsigned N      = 32 / RAM_DW;
  localparam int unsigned BEAT_W = (N > 2) ? 2 : 1;
  localparam int unsigned BYTES  = RAM_DW / 8;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              act_wr_q, act_wr_d;
  logic              act_big_q, act_big_d;
  logic [ADDR_W-1:0] act_addr_q, act_addr_d;
  logic [31:0]       act_wdata_q, act_wdata_d;
  logic [31:0]       rd_buf_q, rd_buf_d;
  logic              pend_vld_q, pend_vld_d;
  logic              pend_wr_q, pend_wr_d;
  logic              pend_big_q, pend_big_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [31:0]       pend_wdata_q, pend_wdata_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              processing_q, processing_d;
  logic              completed_q, completed_d;
  logic              err_ov_q, err_ov_d;
  logic              err_col_q, err_col_d;
  logic              word_rd_q, word_rd_d;
  logic              word_wr_q, word_wr_d;
  logic [ADDR_W-1:0] word_addr_q, word_addr_d;
  logic [RAM_DW-1:0] word_data_q, word_data_d;

  logic              req_v;
  logic [ADDR_W-1:0] req_base;
  logic [BEAT_W-1:0] lane;
  logic              ov_set;

  // Word alignment drops the two low address bits.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.bridge_addr[1:0];

  // State and datapath registers.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      beat_q       <= '0;
      act_wr_q     <= 1'b0;
      act_big_q    <= 1'b0;
      act_addr_q   <= '0;
      act_wdata_q  <= '0;
      rd_buf_q     <= '0;
      pend_vld_q   <= 1'b0;
      pend_wr_q    <= 1'b0;
      pend_big_q   <= 1'b0;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
      rd_data_q    <= '0;
      processing_q <= 1'b0;
      completed_q  <= 1'b0;
      err_ov_q     <= 1'b0;
      err_col_q    <= 1'b0;
      word_rd_q    <= 1'b0;
      word_wr_q    <= 1'b0;
      word_addr_q  <= '0;
      word_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      act_wr_q     <= act_wr_d;
      act_big_q    <= act_big_d;
      act_addr_q   <= act_addr_d;
      act_wdata_q  <= act_wdata_d;
      rd_buf_q     <= rd_buf_d;
      pend_vld_q   <= pend_vld_d;
      pend_wr_q    <= pend_wr_d;
      pend_big_q   <= pend_big_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
      rd_data_q    <= rd_data_d;
      processing_q <= processing_d;
      completed_q  <= completed_d;
      err_ov_q     <= err_ov_d;
      err_col_q    <= err_col_d;
      word_rd_q    <= word_rd_d;
      word_wr_q    <= word_wr_d;
      word_addr_q  <= word_addr_d;
      word_data_q  <= word_data_d;
    end
  end

  // Next-state, request routing and beat sequencing.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    act_wr_d     = act_wr_q;
    act_big_d    = act_big_q;
    act_addr_d   = act_addr_q;
    act_wdata_d  = act_wdata_q;
    rd_buf_d     = rd_buf_q;
    pend_vld_d   = pend_vld_q;
    pend_wr_d    = pend_wr_q;
    pend_big_d   = pend_big_q;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;
    rd_data_d    = rd_data_q;
    completed_d  = 1'b0;
    word_rd_d    = 1'b0;
    word_wr_d    = 1'b0;
    word_addr_d  = word_addr_q;
    word_data_d  = word_data_q;
    ov_set       = 1'b0;
    req_v        = (bus.bridge_rd | bus.bridge_wr) && (bus.bridge_addr[31:24] != IGNORE_PREFIX);
    req_base     = {bus.bridge_addr[ADDR_W-1:2], 2'b00};
    lane         = act_big_q ? (BEAT_W'(N - 1) - beat_q) : beat_q;

    case (state_q)
      S_IDLE: begin
        if (pend_vld_q) begin
          act_wr_d    = pend_wr_q;
          act_big_d   = pend_big_q;
          act_addr_d  = pend_addr_q;
          act_wdata_d = pend_wdata_q;
          pend_vld_d  = 1'b0;
          beat_d      = '0;
          state_d     = S_ISSUE;
        end else if (req_v) begin
          act_wr_d    = bus.bridge_wr;
          act_big_d   = bus.bigendin;
          act_addr_d  = req_base;
          act_wdata_d = bus.bridge_wr_data;
          beat_d      = '0;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!bus.word_busy) begin
          word_rd_d   = ~act_wr_q;
          word_wr_d   = act_wr_q;
          word_addr_d = act_addr_q + ADDR_W'(beat_q) * ADDR_W'(BYTES);
          for (int unsigned i = 0; i < N; i++) begin
            if (BEAT_W'(i) == lane) word_data_d = act_wdata_q[i*RAM_DW +: RAM_DW];
          end
          state_d = S_GAP;
        end
      end
      S_GAP: state_d = S_WAIT;
      S_WAIT: begin
        if (!bus.word_busy) begin
          if (!act_wr_q) begin
            for (int unsigned i = 0; i < N; i++) begin
              if (BEAT_W'(i) == lane) rd_buf_d[i*RAM_DW +: RAM_DW] = bus.word_q;
            end
          end
          if (beat_q == BEAT_W'(N - 1)) begin
            completed_d = 1'b1;
            if (!act_wr_q) rd_data_d = rd_buf_d;
            state_d = S_IDLE;
          end else begin
            beat_d  = beat_q + BEAT_W'(1);
            state_d = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Any request not taken as the active transaction goes to the pending slot or is dropped.
    if (req_v && !(state_q == S_IDLE && !pend_vld_q)) begin
      if (!pend_vld_d) begin
        pend_vld_d   = 1'b1;
        pend_wr_d    = bus.bridge_wr;
        pend_big_d   = bus.bigendin;
        pend_addr_d  = req_base;
        pend_wdata_d = bus.bridge_wr_data;
      end else begin
        ov_set = 1'b1;
      end
    end

    err_ov_d     = bus.err_clear ? 1'b0 : (err_ov_q | ov_set);
    err_col_d    = bus.err_clear ? 1'b0 : (err_col_q | (bus.bridge_rd & bus.bridge_wr));
    processing_d = (state_d != S_IDLE) || pend_vld_d;
  end

  assign bus.bridge_rd_data    = rd_data_q;
  assign bus.bridge_processing = processing_q;
  assign bus.bridge_completed  = completed_q;
  assign bus.err_overflow      = err_ov_q;
  assign bus.err_collision     = err_col_q;
  assign bus.word_rd           = word_rd_q;
  assign bus.word_wr           = word_wr_q;
  assign bus.word_addr         = word_addr_q;
  assign bus.word_data         = word_data_q;
endmodule

// File: tb/tb_ram_bridge_width_adapter.sv
// Directed bench for ram_bridge_width_adapter: one 8-bit and one 16-bit instance,
// with strobes and completions logged per edge number relative to the request edge.
module tb_ram_bridge_width_adapter;
  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_sys = ~clk_sys;

  ram_bridge_width_adapter_if #(.RAM_DW(8),  .ADDR_W(26)) if8 ();
  ram_bridge_width_adapter_if #(.RAM_DW(16), .ADDR_W(26)) if16 ();

  ram_bridge_width_adapter #(.RAM_DW(8),  .ADDR_W(26), .IGNORE_PREFIX(8'hF8))
    dut8 (.clk_sys(clk_sys), .reset(reset), .bus(if8));
  ram_bridge_width_adapter #(.RAM_DW(16), .ADDR_W(26), .IGNORE_PREFIX(8'hF8))
    dut16 (.clk_sys(clk_sys), .reset(reset), .bus(if16));

  // RAM read models keyed on the presented address.
  always_comb begin
    case (if8.word_addr[1:0])
      2'd0:    if8.word_q = 8'hA1;
      2'd1:    if8.word_q = 8'hB2;
      2'd2:    if8.word_q = 8'hC3;
      default: if8.word_q = 8'hD4;
    endcase
    if16.word_q = if16.word_addr[1] ? 16'hDEAD : 16'hBEEF;
  end

  int n_pass = 0, n_fail = 0, n_total = 0;
  int ecnt, busy_lo, busy_hi;
  logic [31:0] s8_addr[$], s8_data[$], s16_addr[$], s16_data[$];
  int          s8_edge[$], s16_edge[$], c8_edge[$], c16_edge[$];
  bit          s8_wr[$];
  logic        proc_log [0:127];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic start_log();
    ecnt = -1; busy_lo = -1; busy_hi = -1;
    s8_addr.delete(); s8_data.delete(); s8_edge.delete(); s8_wr.delete(); c8_edge.delete();
    s16_addr.delete(); s16_data.delete(); s16_edge.delete(); c16_edge.delete();
  endtask

  task automatic step();
    ecnt++;
    if8.word_busy  = (ecnt >= busy_lo) && (ecnt <= busy_hi);
    if16.word_busy = 1'b0;
    @(posedge clk_sys); #1;
    if (ecnt >= 0 && ecnt < 128) proc_log[ecnt] = if8.bridge_processing;
    if (if8.word_wr || if8.word_rd) begin
      s8_addr.push_back(32'(if8.word_addr)); s8_data.push_back(32'(if8.word_data));
      s8_edge.push_back(ecnt); s8_wr.push_back(if8.word_wr);
    end
    if (if16.word_wr || if16.word_rd) begin
      s16_addr.push_back(32'(if16.word_addr)); s16_data.push_back(32'(if16.word_data));
      s16_edge.push_back(ecnt);
    end
    if (if8.bridge_completed)  c8_edge.push_back(ecnt);
    if (if16.bridge_completed) c16_edge.push_back(ecnt);
  endtask

  task automatic run(input int last_edge);
    while (ecnt < last_edge) step();
  endtask

  task automatic req(input bit sel16, input bit rd, input bit wr, input logic [31:0] addr,
                     input logic [31:0] data, input bit big);
    if (sel16) begin
      if16.bridge_rd = rd; if16.bridge_wr = wr; if16.bridge_addr = addr;
      if16.bridge_wr_data = data; if16.bigendin = big;
    end else begin
      if8.bridge_rd = rd; if8.bridge_wr = wr; if8.bridge_addr = addr;
      if8.bridge_wr_data = data; if8.bigendin = big;
    end
    step();
    if8.bridge_rd = 1'b0; if8.bridge_wr = 1'b0; if16.bridge_rd = 1'b0; if16.bridge_wr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_b[4];
    if8.bigendin = 0; if8.bridge_addr = 0; if8.bridge_rd = 0; if8.bridge_wr = 0;
    if8.bridge_wr_data = 0; if8.err_clear = 0; if8.word_busy = 0;
    if16.bigendin = 0; if16.bridge_addr = 0; if16.bridge_rd = 0; if16.bridge_wr = 0;
    if16.bridge_wr_data = 0; if16.err_clear = 0; if16.word_busy = 0;

    // Reset values.
    #22;
    check("rst_rd_data", if8.bridge_rd_data, 32'h0);
    check("rst_proc",    32'(if8.bridge_processing), 32'h0);
    check("rst_strobes", 32'({if8.word_rd, if8.word_wr, if8.bridge_completed}), 32'h0);
    check("rst_errs",    32'({if8.err_overflow, if8.err_collision}), 32'h0);
    check("rst_waddr",   32'(if8.word_addr), 32'h0);
    check("rst16_word",  32'({if16.word_rd, if16.word_wr, if16.word_data}), 32'h0);
    #4 reset = 1'b0;
    @(posedge clk_sys); #1;

    // 8-bit big-endian write.
    start_log();
    req(0, 0, 1, 32'h0000_0100, 32'h1122_3344, 1);
    run(20);
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    check("t1_nstrobe", 32'(s8_addr.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t1_addr%0d", k), s8_addr[k], 32'h100 + 32'(k));
      check($sformatf("t1_data%0d", k), s8_data[k], 32'(exp_b[k]));
      check($sformatf("t1_edge%0d", k), 32'(s8_edge[k]), 32'(1 + 3 * k));
    end
    check("t1_wr_type",  32'(s8_wr[0]), 32'd1);
    check("t1_ncomp",    32'(c8_edge.size()), 32'd1);
    check("t1_comp_e",   32'(c8_edge[0]), 32'd12);
    check("t1_proc_e0",  32'(proc_log[0]), 32'd1);
    check("t1_proc_e11", 32'(proc_log[11]), 32'd1);
    check("t1_proc_e12", 32'(proc_log[12]), 32'd0);
    check("t1_rd_data",  if8.bridge_rd_data, 32'h0);

    // 16-bit little-endian read.
    start_log();
    req(1, 1, 0, 32'h0000_0200, 32'h0, 0);
    run(12);
    check("t2_nstrobe", 32'(s16_addr.size()), 32'd2);
    check("t2_addr0",   s16_addr[0], 32'h200);
    check("t2_addr1",   s16_addr[1], 32'h202);
    check("t2_edge1",   32'(s16_edge[1]), 32'd4);
    check("t2_ncomp",   32'(c16_edge.size()), 32'd1);
    check("t2_comp_e",  32'(c16_edge[0]), 32'd6);
    check("t2_rd_data", if16.bridge_rd_data, 32'hDEAD_BEEF);

    // 8-bit big-endian read of an unaligned address, busy 5 cycles in beat 2's wait.
    start_log();
    busy_lo = 9; busy_hi = 13;
    req(0, 1, 0, 32'h0000_0107, 32'h0, 1);
    run(25);
    check("t3_addr0",   s8_addr[0], 32'h104);
    check("t3_edge3",   32'(s8_edge[3]), 32'd15);
    check("t3_ncomp",   32'(c8_edge.size()), 32'd1);
    check("t3_comp_e",  32'(c8_edge[0]), 32'd17);
    check("t3_rd_data", if8.bridge_rd_data, 32'hA1B2_C3D4);

    // Three back-to-back writes: second pends, third overflows.
    start_log();
    req(0, 0, 1, 32'h0000_0180, 32'h0102_0304, 1);
    req(0, 0, 1, 32'h0000_0200, 32'hCAFE_F00D, 0);
    req(0, 0, 1, 32'h0000_0300, 32'h9999_9999, 1);
    run(40);
    check("t4_ncomp",    32'(c8_edge.size()), 32'd2);
    check("t4_comp0_e",  32'(c8_edge[0]), 32'd12);
    check("t4_comp1_e",  32'(c8_edge[1]), 32'd25);
    check("t4_nstrobe",  32'(s8_addr.size()), 32'd8);
    check("t4_b_addr0",  s8_addr[4], 32'h200);
    check("t4_b_data0",  s8_data[4], 32'h0D);
    check("t4_b_data3",  s8_data[7], 32'hCA);
    check("t4_b_edge0",  32'(s8_edge[4]), 32'd14);
    check("t4_proc_e12", 32'(proc_log[12]), 32'd1);
    check("t4_proc_e25", 32'(proc_log[25]), 32'd0);
    check("t4_err_ov",   32'(if8.err_overflow), 32'd1);
    check("t4_err_col",  32'(if8.err_collision), 32'd0);

    // Ignored prefix, then a collision request taken as a write.
    start_log();
    req(0, 1, 0, 32'hF800_0000, 32'h0, 1);
    run(15);
    check("t5_ign_strb", 32'(s8_addr.size()), 32'd0);
    check("t5_ign_comp", 32'(c8_edge.size()), 32'd0);
    check("t5_ign_proc", 32'(proc_log[0]), 32'd0);
    start_log();
    req(0, 1, 1, 32'h0000_0300, 32'h5566_7788, 1);
    run(14);
    check("t5_col_strb", 32'(s8_addr.size()), 32'd4);
    check("t5_col_wr",   32'(s8_wr[0]), 32'd1);
    check("t5_col_data", s8_data[0], 32'h55);
    check("t5_col_comp", 32'(c8_edge.size()), 32'd1);
    check("t5_err_col",  32'(if8.err_collision), 32'd1);
    check("t5_rd_keep",  if8.bridge_rd_data, 32'hA1B2_C3D4);
    if8.err_clear = 1'b1;
    step();
    if8.err_clear = 1'b0;
    check("t5_clr_errs", 32'({if8.err_overflow, if8.err_collision}), 32'h0);

    // Reset during beat 1, then a fresh read.
    start_log();
    req(0, 1, 0, 32'h0000_0108, 32'h0, 1);
    run(4);
    check("t6_pre_rd",   32'(if8.word_rd), 32'd1);
    check("t6_pre_addr", 32'(if8.word_addr), 32'h109);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_strb", 32'({if8.word_rd, if8.word_wr}), 32'h0);
    check("t6_rst_out",  32'({if8.bridge_processing, if8.bridge_completed, if8.word_addr}), 32'h0);
    check("t6_rst_data", if8.bridge_rd_data, 32'h0);
    #2 reset = 1'b0;
    start_log();
    req(0, 1, 0, 32'h0000_010C, 32'h0, 0);
    run(20);
    check("t6_ncomp",   32'(c8_edge.size()), 32'd1);
    check("t6_comp_e",  32'(c8_edge[0]), 32'd12);
    check("t6_addr0",   s8_addr[0], 32'h10C);
    check("t6_rd_data", if8.bridge_rd_data, 32'hD4C3_B2A1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
